packet_transfer_buffer_mc: RTL and testbench

Parametrised multi-channel successor to the single-channel packet transfer buffer in the packet controller. It merges up to `CHANNELS` flit streams into one circular flit FIFO, with packet-granular round-robin arbitration, so a packet is never interleaved with another. It feeds the downstream packet router through a valid/ready output. An optional store-and-forward mode holds each packet until its tail flit is buffered.

---
 rtl/packet_transfer_buffer_mc_if.sv | 32 +++
 rtl/packet_transfer_buffer_mc.sv | 124 ++++++++++++
 tb/tb_packet_transfer_buffer_mc.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/packet_transfer_buffer_mc_if.sv
// Bundle for packet_transfer_buffer_mc: per-channel flit inputs, the FWFT
// output port and the occupancy counters.
interface packet_transfer_buffer_mc_if #(
  parameter int unsigned FLIT_WIDTH = 64,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned CHANNELS   = 2
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0]            in_valid;
  logic [CHANNELS-1:0]            in_ready;
  logic [CHANNELS*FLIT_WIDTH-1:0] in_flit;
  logic [CHANNELS-1:0]            in_tail;
  logic                           out_valid;
  logic                           out_ready;
  logic [FLIT_WIDTH-1:0]          out_flit;
  logic                           out_tail;
  logic [CW-1:0]                  out_channel;
  logic [AW:0]                    count;
  logic [AW:0]                    packet_count;

  modport master (
    output in_valid, in_flit, in_tail, out_ready,
    input  in_ready, out_valid, out_flit, out_tail, out_channel, count, packet_count
  );

  modport slave (
    input  in_valid, in_flit, in_tail, out_ready,
    output in_ready, out_valid, out_flit, out_tail, out_channel, count, packet_count
  );
endinterface

// File: rtl/packet_transfer_buffer_mc.sv
// Multi-channel packet FIFO with packet-granular round-robin arbitration.
// Define PACKET_BUFFER_STORE_FORWARD_EN to hold packets until their tail is stored.
module packet_transfer_buffer_mc #(
  parameter int unsigned FLIT_WIDTH = 64,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned CHANNELS   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  packet_transfer_buffer_mc_if.slave   bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef struct packed {
    logic [CW-1:0]         channel;
    logic                  tail;
    logic [FLIT_WIDTH-1:0] flit;
  } entry_t;

  typedef enum logic {ST_OPEN, ST_LOCKED} lock_state_t;

  entry_t                mem [DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr, count_q, pcount_q;
  lock_state_t           state_q, state_d;
  logic [CW-1:0]         lock_ch, rr_ptr, grant, cand;
  logic                  grant_valid, full, empty, wr_en, rd_en, out_valid_c;
  logic                  tail_wr, tail_rd;
  logic [CHANNELS-1:0]   ready_c;
  logic [FLIT_WIDTH-1:0] flits [CHANNELS];
  int unsigned           idx;
  entry_t                wr_entry, head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});

  // Grant is pinned to the lock owner mid-packet, else first valid after rr_ptr.
  always_comb begin
    grant       = lock_ch;
    grant_valid = 1'b0;
    idx         = 0;
    cand        = '0;
    if (state_q == ST_LOCKED) begin
      grant_valid = 1'b1;
    end else begin
      for (int unsigned k = 1; k <= CHANNELS; k++) begin
        idx  = (32'(rr_ptr) + k) % CHANNELS;
        cand = CW'(idx);
        if (!grant_valid && bus.in_valid[cand]) begin
          grant       = cand;
          grant_valid = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ready_c = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      flits[i]   = bus.in_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
      ready_c[i] = grant_valid && (grant == CW'(i)) && !full;
    end
  end

  assign wr_entry = '{channel: grant, tail: bus.in_tail[grant], flit: flits[grant]};
  assign wr_en    = |(bus.in_valid & ready_c);
  assign head     = mem[rd_ptr[AW-1:0]];

`ifdef PACKET_BUFFER_STORE_FORWARD_EN
  // Full acts as the escape for packets longer than the FIFO.
  assign out_valid_c = !empty && ((pcount_q != '0) || full);
`else
  assign out_valid_c = !empty;
`endif

  assign rd_en   = out_valid_c && bus.out_ready;
  assign tail_wr = wr_en && wr_entry.tail;
  assign tail_rd = rd_en && head.tail;

  // Lock opens on a non-tail write and closes on the tail.
  always_comb begin
    state_d = state_q;
    if (wr_en) begin
      state_d = wr_entry.tail ? ST_OPEN : ST_LOCKED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_OPEN;
      lock_ch  <= '0;
      rr_ptr   <= CW'(CHANNELS - 1);
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      pcount_q <= '0;
    end else begin
      state_q <= state_d;
      if (wr_en) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
        if (wr_entry.tail) rr_ptr  <= grant;
        else               lock_ch <= grant;
      end
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
      if (wr_en && !rd_en)      count_q <= count_q + (AW+1)'(1);
      else if (!wr_en && rd_en) count_q <= count_q - (AW+1)'(1);
      if (tail_wr && !tail_rd)      pcount_q <= pcount_q + (AW+1)'(1);
      else if (!tail_wr && tail_rd) pcount_q <= pcount_q - (AW+1)'(1);
    end
  end

  // Storage is not reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_entry;
  end

  assign bus.in_ready     = ready_c;
  assign bus.out_valid    = out_valid_c;
  assign bus.out_flit     = head.flit;
  assign bus.out_tail     = head.tail;
  assign bus.out_channel  = head.channel;
  assign bus.count        = count_q;
  assign bus.packet_count = pcount_q;
endmodule

// File: tb/tb_packet_transfer_buffer_mc.sv
// Scoreboard bench for packet_transfer_buffer_mc (DEPTH=4, CHANNELS=2); also
// covers the PACKET_BUFFER_STORE_FORWARD_EN build.
module tb_packet_transfer_buffer_mc;
  localparam int unsigned FW = 64;
  localparam int unsigned D  = 4;
  localparam int unsigned C  = 2;
`ifdef PACKET_BUFFER_STORE_FORWARD_EN
  localparam bit SF = 1'b1;
`else
  localparam bit SF = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] flit;
    logic        tail;
    logic        ch;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  packet_transfer_buffer_mc_if #(.FLIT_WIDTH(FW), .DEPTH(D), .CHANNELS(C)) bus ();

  packet_transfer_buffer_mc #(.FLIT_WIDTH(FW), .DEPTH(D), .CHANNELS(C)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every accepted output flit is matched against the scoreboard head.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_out: got flit %0h with no expected entry at %0t", bus.out_flit, $time);
      end else begin
        mon_e = sb.pop_front();
        chk("out_flit", bus.out_flit, mon_e.flit);
        chk("out_tail", 64'(bus.out_tail), 64'(mon_e.tail));
        chk("out_channel", 64'(bus.out_channel), 64'(mon_e.ch));
      end
    end
  end

  // One cycle: drive inputs, check at negedge, queue expected accepts. Negative exp_* skips.
  task automatic step(input logic [1:0] iv, input logic [63:0] f0, input logic t0,
                      input logic [63:0] f1, input logic t1, input logic ordy,
                      input logic [1:0] exp_rdy, input int exp_ov, input int exp_cnt,
                      input int exp_pc);
    exp_t e;
    bus.in_valid  = iv;
    bus.in_flit   = {f1, f0};
    bus.in_tail   = {t1, t0};
    bus.out_ready = ordy;
    @(negedge clk);
    chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    if (exp_ov >= 0)  chk("out_valid", 64'(bus.out_valid), 64'(exp_ov));
    if (exp_cnt >= 0) chk("count", 64'(bus.count), 64'(exp_cnt));
    if (exp_pc >= 0)  chk("packet_count", 64'(bus.packet_count), 64'(exp_pc));
    for (int i = 0; i < 2; i++) begin
      if (iv[i] && exp_rdy[i]) begin
        e.flit = (i == 1) ? f1 : f0;
        e.tail = (i == 1) ? t1 : t0;
        e.ch   = 1'(i);
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.in_valid  = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.count == '0) break;
      @(posedge clk);
    end
    chk("drain_count", 64'(bus.count), 64'd0);
    chk("drain_scoreboard", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.in_valid  = '0;
    bus.in_flit   = '0;
    bus.in_tail   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset values, including the still-asserted cycle.
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_count", 64'(bus.count), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(2'b00, 0, 0, 0, 0, 1'b0, 2'b00, 0, 0, 0);

    // Cut-through three-flit packet on channel 0.
    step(2'b01, 64'hA1, 0, 0, 0, 1'b1, 2'b01, 0, 0, 0);
    step(2'b01, 64'hA2, 0, 0, 0, 1'b1, 2'b01, SF ? 0 : 1, 1, 0);
    step(2'b01, 64'hA3, 1, 0, 0, 1'b1, 2'b01, SF ? 0 : 1, SF ? 2 : 1, 0);
    step(2'b00, 0, 0, 0, 0, 1'b1, 2'b00, 1, SF ? 3 : 1, 1);
    step(2'b00, 0, 0, 0, 0, 1'b1, 2'b00, SF ? 1 : 0, SF ? 2 : 0, SF ? 1 : 0);
    drain();

    // Contention: rr_ptr=0 so channel 1 first, then channel 0 holds the lock through a gap.
    step(2'b10, 0, 0, 64'hB0, 1, 1'b1, 2'b10, -1, -1, -1);
    step(2'b11, 64'hC1, 0, 64'hD1, 1, 1'b1, 2'b01, -1, -1, -1);
    step(2'b11, 64'hC2, 0, 64'hD1, 1, 1'b1, 2'b01, -1, -1, -1);
    step(2'b10, 0, 0, 64'hD1, 1, 1'b1, 2'b01, -1, -1, -1);
    step(2'b11, 64'hC3, 1, 64'hD1, 1, 1'b1, 2'b01, -1, -1, -1);
    step(2'b10, 0, 0, 64'hD1, 1, 1'b1, 2'b10, -1, -1, -1);
    step(2'b11, 64'hE1, 1, 64'hF1, 1, 1'b1, 2'b01, -1, -1, -1);
    step(2'b10, 0, 0, 64'hF1, 1, 1'b1, 2'b10, -1, -1, -1);
    drain();

    // Fill to DEPTH, then a same-cycle read must not let the write through.
    step(2'b01, 64'h61, 1, 0, 0, 1'b0, 2'b01, 0, 0, 0);
    step(2'b01, 64'h62, 1, 0, 0, 1'b0, 2'b01, 1, 1, 1);
    step(2'b01, 64'h63, 1, 0, 0, 1'b0, 2'b01, 1, 2, 2);
    step(2'b01, 64'h64, 1, 0, 0, 1'b0, 2'b01, 1, 3, 3);
    step(2'b01, 64'h65, 1, 0, 0, 1'b0, 2'b00, 1, 4, 4);
    step(2'b01, 64'h65, 1, 0, 0, 1'b1, 2'b00, 1, 4, 4);
    step(2'b01, 64'h65, 1, 0, 0, 1'b1, 2'b01, 1, 3, 3);
    drain();

`ifdef PACKET_BUFFER_STORE_FORWARD_EN
    // Oversize packet drains through the full fallback.
    step(2'b01, 64'h71, 0, 0, 0, 1'b1, 2'b01, 0, 0, 0);
    step(2'b01, 64'h72, 0, 0, 0, 1'b1, 2'b01, 0, 1, 0);
    step(2'b01, 64'h73, 0, 0, 0, 1'b1, 2'b01, 0, 2, 0);
    step(2'b01, 64'h74, 0, 0, 0, 1'b1, 2'b01, 0, 3, 0);
    step(2'b01, 64'h75, 0, 0, 0, 1'b1, 2'b00, 1, 4, 0);
    step(2'b01, 64'h75, 0, 0, 0, 1'b1, 2'b01, 0, 3, 0);
    step(2'b01, 64'h76, 1, 0, 0, 1'b1, 2'b00, 1, 4, 0);
    step(2'b01, 64'h76, 1, 0, 0, 1'b1, 2'b01, 0, 3, 0);
    step(2'b00, 0, 0, 0, 0, 1'b1, 2'b00, 1, 4, 1);
    drain();
`endif

    // Reset mid-packet: storage and channel-0 lock are discarded.
    step(2'b01, 64'h81, 0, 0, 0, 1'b0, 2'b01, -1, 0, 0);
    step(2'b01, 64'h82, 0, 0, 0, 1'b0, 2'b01, -1, 1, 0);
    rst = 1'b1;
    bus.in_valid = '0;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(2'b10, 0, 0, 64'h91, 1, 1'b1, 2'b10, 0, 0, 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
